// File: rtl/segment_pkg.sv
// Shared types and defaults for the per-box segment statistics path.
// Provides RGB444 nibble selectors, the pixel type, the default VGA band
// geometry and width helpers for the per-box accumulators.
package segment_pkg;

    localparam int unsigned CH_RED   = 2;
    localparam int unsigned CH_GREEN = 1;
    localparam int unsigned CH_BLUE  = 0;

    localparam int unsigned PIXEL_W = 12;
    typedef logic [PIXEL_W-1:0] pixel_t;

    localparam int unsigned DEF_X0      = 51;
    localparam int unsigned DEF_X_PITCH = 90;
    localparam int unsigned DEF_BOX_W   = 74;
    localparam int unsigned DEF_Y_TOP   = 151;
    localparam int unsigned DEF_Y_BOT   = 299;

    // A full row of a box summed at nibble value 15 must fit.
    function automatic int unsigned sumWidth(input int unsigned boxW);
        return 4 + $clog2(boxW);
    endfunction

    // Every pixel of a box over the whole band may be foreground.
    function automatic int unsigned cntWidth(input int unsigned boxW, input int unsigned rows);
        return $clog2(boxW * rows + 1);
    endfunction

endpackage

// File: rtl/box_decode.sv
// Combinational box decoder shared with the overlay generator.
// Ports: hPos/vPos   - pixel position
//        inBand_c    - row lies inside the box band
//        boxHit_c    - column lies inside one of the NUM_BOX boxes
//        boxIdx_c    - index of the hit box (0 when no hit)
module box_decode
    import segment_pkg::*;
#(
    parameter int unsigned NUM_BOX = 6,
    parameter int unsigned X0      = DEF_X0,
    parameter int unsigned X_PITCH = DEF_X_PITCH,
    parameter int unsigned BOX_W   = DEF_BOX_W,
    parameter int unsigned Y_TOP   = DEF_Y_TOP,
    parameter int unsigned Y_BOT   = DEF_Y_BOT
) (
    input  logic [9:0] hPos,
    input  logic [9:0] vPos,
    output logic       inBand_c,
    output logic       boxHit_c,
    output logic [2:0] boxIdx_c
);

    // Boxes must not overlap, and the index has to fit in 3 bits.
    if (X_PITCH < BOX_W) begin : gOverlapCheck
        $error("box_decode: X_PITCH must be >= BOX_W");
    end
    if (NUM_BOX < 1 || NUM_BOX > 8) begin : gNumBoxCheck
        $error("box_decode: NUM_BOX must be in 1..8");
    end

    assign inBand_c = (32'(vPos) >= Y_TOP) && (32'(vPos) <= Y_BOT);

    // Non-overlapping boxes mean at most one iteration can match.
    always_comb begin
        boxHit_c = 1'b0;
        boxIdx_c = '0;
        for (int unsigned k = 0; k < NUM_BOX; k++) begin
            if ((32'(hPos) >= X0 + k * X_PITCH) && (32'(hPos) < X0 + k * X_PITCH + BOX_W)) begin
                boxHit_c = 1'b1;
                boxIdx_c = 3'(k);
            end
        end
    end

endmodule

// File: rtl/segment_profiler.sv
// Per-character-box statistics engine on the VGA pixel path.
// Masks the gaps between boxes inside the band, and per frame accumulates the
// selected colour nibble along the probe row plus a foreground pixel count per
// box. Results are latched once per frame and read back by box index.
// Ports: clk, rst_n         - pixel clock, async active-low reset
//        hcnt, vcnt, pixel_in - incoming raster position and RGB444 pixel
//        pixel_out          - masked pixel, one clock after pixel_in
//        rd_idx             - box index for the combinational read port
//        rd_row_sum, rd_fg_count - latched results of box rd_idx
//        results_valid      - one-cycle pulse on each commit
//        frame_count        - commits since reset (wrapping)
module segment_profiler
    import segment_pkg::*;
#(
    parameter int unsigned NUM_BOX   = 6,
    parameter int unsigned X0        = DEF_X0,
    parameter int unsigned X_PITCH   = DEF_X_PITCH,
    parameter int unsigned BOX_W     = DEF_BOX_W,
    parameter int unsigned Y_TOP     = DEF_Y_TOP,
    parameter int unsigned Y_BOT     = DEF_Y_BOT,
    parameter int unsigned PROBE_ROW = 200,
    parameter int unsigned CH_SEL    = CH_RED,
    parameter int unsigned THRESH    = 8,
    parameter int unsigned SUM_W     = sumWidth(BOX_W),
    parameter int unsigned CNT_W     = cntWidth(BOX_W, Y_BOT - Y_TOP + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [9:0]       hcnt,
    input  logic [9:0]       vcnt,
    input  logic [11:0]      pixel_in,
    output logic [11:0]      pixel_out,
    input  logic [2:0]       rd_idx,
    output logic [SUM_W-1:0] rd_row_sum,
    output logic [CNT_W-1:0] rd_fg_count,
    output logic             results_valid,
    output logic [7:0]       frame_count
);

    if (CH_SEL > CH_RED) begin : gChSelCheck
        $error("segment_profiler: CH_SEL must be 0..2");
    end

    // Decode once on the incoming counters; registering the result next to
    // h/v gives stage 1 the decode of its own registered position.
    logic       inBandIn;
    logic       boxHitIn;
    logic [2:0] boxIdxIn;

    box_decode #(
        .NUM_BOX(NUM_BOX), .X0(X0), .X_PITCH(X_PITCH),
        .BOX_W(BOX_W), .Y_TOP(Y_TOP), .Y_BOT(Y_BOT)
    ) uDecode (
        .hPos    (hcnt),
        .vPos    (vcnt),
        .inBand_c(inBandIn),
        .boxHit_c(boxHitIn),
        .boxIdx_c(boxIdxIn)
    );

    pixel_t pixMasked;
    assign pixMasked = (inBandIn && !boxHitIn) ? pixel_t'(0) : pixel_t'(pixel_in);

    // Stage 1. s1Valid keeps the reset contents of hReg/vReg (0,0) from
    // looking like a frame start on the first edge after reset.
    logic [9:0] hReg;
    logic [9:0] vReg;
    logic [3:0] nibReg;
    logic       s1Valid;
    logic       s1InBand;
    logic       s1Hit;
    logic [2:0] s1Idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hReg      <= '0;
            vReg      <= '0;
            nibReg    <= '0;
            s1Valid   <= 1'b0;
            s1InBand  <= 1'b0;
            s1Hit     <= 1'b0;
            s1Idx     <= '0;
            pixel_out <= '0;
        end else begin
            hReg      <= hcnt;
            vReg      <= vcnt;
            nibReg    <= pixel_in[CH_SEL*4 +: 4];
            s1Valid   <= 1'b1;
            s1InBand  <= inBandIn;
            s1Hit     <= boxHitIn;
            s1Idx     <= boxIdxIn;
            pixel_out <= pixMasked;
        end
    end

    logic frameStart;
    logic commit;
    logic armed;

    assign frameStart = s1Valid && (vReg == 10'd0) && (hReg == 10'd0);
    assign commit     = s1Valid && armed && (vReg == 10'(Y_BOT + 1)) && (hReg == 10'd0);

    logic [SUM_W-1:0] rowAcc [NUM_BOX];
    logic [CNT_W-1:0] fgAcc  [NUM_BOX];
    logic [SUM_W-1:0] rowRes [NUM_BOX];
    logic [CNT_W-1:0] fgRes  [NUM_BOX];

    // Frame start, commit and band accumulation occupy disjoint rows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NUM_BOX; k++) begin
                rowAcc[k] <= '0;
                fgAcc[k]  <= '0;
                rowRes[k] <= '0;
                fgRes[k]  <= '0;
            end
            armed         <= 1'b0;
            results_valid <= 1'b0;
            frame_count   <= '0;
        end else begin
            results_valid <= commit;
            if (frameStart) begin
                for (int unsigned k = 0; k < NUM_BOX; k++) begin
                    rowAcc[k] <= '0;
                    fgAcc[k]  <= '0;
                end
                armed <= 1'b1;
            end else if (commit) begin
                for (int unsigned k = 0; k < NUM_BOX; k++) begin
                    rowRes[k] <= rowAcc[k];
                    fgRes[k]  <= fgAcc[k];
                end
                armed       <= 1'b0;
                frame_count <= frame_count + 8'd1;
            end else if (s1InBand && s1Hit) begin
                for (int unsigned k = 0; k < NUM_BOX; k++) begin
                    if (32'(s1Idx) == k) begin
                        if (vReg == 10'(PROBE_ROW)) begin
                            rowAcc[k] <= rowAcc[k] + SUM_W'(nibReg);
                        end
                        if (({1'b0, nibReg} < 5'(THRESH)) && (fgAcc[k] != {CNT_W{1'b1}})) begin
                            fgAcc[k] <= fgAcc[k] + CNT_W'(1);
                        end
                    end
                end
            end
        end
    end

    // Out-of-range indices fall through to zero.
    always_comb begin
        rd_row_sum  = '0;
        rd_fg_count = '0;
        for (int unsigned k = 0; k < NUM_BOX; k++) begin
            if (32'(rd_idx) == k) begin
                rd_row_sum  = rowRes[k];
                rd_fg_count = fgRes[k];
            end
        end
    end

endmodule
